// File: rtl/mult8x8_seq_sched.sv
// Two-requester 8x8 unsigned multiplier that time-shares one combinational 4x4 core.
// Round-robin grant in IDLE, four partial products accumulated over four MUL cycles.

module mult_2x2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] y
);
  logic p00, p10, p01, p11, c1;

  always_comb begin
    p00  = a[0] & b[0];
    p10  = a[1] & b[0];
    p01  = a[0] & b[1];
    p11  = a[1] & b[1];
    c1   = p10 & p01;
    y[0] = p00;
    y[1] = p10 ^ p01;
    y[2] = p11 ^ c1;
    y[3] = p11 & c1;
  end
endmodule

module mult_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] y
);
  logic [3:0] y_ll, y_hl, y_lh, y_hh;

  mult_2x2 u_ll (.a(a[1:0]), .b(b[1:0]), .y(y_ll));
  mult_2x2 u_hl (.a(a[3:2]), .b(b[1:0]), .y(y_hl));
  mult_2x2 u_lh (.a(a[1:0]), .b(b[3:2]), .y(y_lh));
  mult_2x2 u_hh (.a(a[3:2]), .b(b[3:2]), .y(y_hh));

  always_comb begin
    y = {4'h0, y_ll}
      + {2'b00, y_hl, 2'b00}
      + {2'b00, y_lh, 2'b00}
      + {y_hh, 4'h0};
  end
endmodule

// state | meaning
// IDLE  | arbitrating, readies may assert
// MUL   | issuing partial product `step` (0..3) to the shared core
// DONE  | holding res_y/res_id until res_ready
module mult8x8_seq_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_y,
  output logic        res_id
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [1:0]  step;
  logic [15:0] acc;
  logic [7:0]  a_q, b_q;
  logic        id_q;
  logic        last_id;
  logic [15:0] res_y_q;
  logic        res_id_q;

  logic        grant0, grant1;
  logic        accept0, accept1;
  logic [3:0]  core_a, core_b;
  logic [7:0]  core_y;
  logic [15:0] term;
  logic [15:0] acc_nxt;

  mult_4x4 u_core (.a(core_a), .b(core_b), .y(core_y));

  // Ties go to whoever did not win last time.
  always_comb begin
    grant0     = req0_valid & (~req1_valid | last_id);
    grant1     = req1_valid & (~req0_valid | ~last_id);
    req0_ready = rst_n & (state == S_IDLE) & grant0;
    req1_ready = rst_n & (state == S_IDLE) & grant1;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
  end

  always_comb begin
    core_a = a_q[3:0];
    core_b = b_q[3:0];
    term   = {8'h00, core_y};
    case (step)
      2'd0: begin
        core_a = a_q[3:0];
        core_b = b_q[3:0];
        term   = {8'h00, core_y};
      end
      2'd1: begin
        core_a = a_q[7:4];
        core_b = b_q[3:0];
        term   = {4'h0, core_y, 4'h0};
      end
      2'd2: begin
        core_a = a_q[3:0];
        core_b = b_q[7:4];
        term   = {4'h0, core_y, 4'h0};
      end
      default: begin
        core_a = a_q[7:4];
        core_b = b_q[7:4];
        term   = {core_y, 8'h00};
      end
    endcase
    acc_nxt = acc + term;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept0 | accept1) state_nxt = S_MUL;
      S_MUL:  if (step == 2'd3) state_nxt = S_DONE;
      S_DONE: if (res_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      step     <= 2'd0;
      acc      <= 16'h0000;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      id_q     <= 1'b0;
      last_id  <= 1'b1;
      res_y_q  <= 16'h0000;
      res_id_q <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (accept0) begin
            a_q     <= req0_a;
            b_q     <= req0_b;
            id_q    <= 1'b0;
            last_id <= 1'b0;
            acc     <= 16'h0000;
            step    <= 2'd0;
          end else if (accept1) begin
            a_q     <= req1_a;
            b_q     <= req1_b;
            id_q    <= 1'b1;
            last_id <= 1'b1;
            acc     <= 16'h0000;
            step    <= 2'd0;
          end
        end
        S_MUL: begin
          acc  <= acc_nxt;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            res_y_q  <= acc_nxt;
            res_id_q <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    res_valid = (state == S_DONE);
    res_y     = res_y_q;
    res_id    = res_id_q;
  end
endmodule
